// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// Stage control word layout: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}.
package mips_pipe_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN    = 8'b1111_1000;
  localparam stage_ctrl_t CTRL_FREEZE = 8'b0000_0000;
  localparam stage_ctrl_t CTRL_BRANCH = 8'b1111_1110;
  localparam stage_ctrl_t CTRL_BUBBLE = 8'b0011_1010;
  // Front end frozen, mul/div slot in EX/MEM replaced by a bubble, MEM/WB drains.
  localparam stage_ctrl_t CTRL_MDHOLD = 8'b0001_1001;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard inputs from the pipeline and stage control strobes back to it.
// master = pipeline side, slave = hazard controller.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       ex_rt;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             ex_md_start;
  logic             md_done;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, ex_branch_taken,
           ex_md_start, md_done, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, md_timeout, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, ex_branch_taken,
           ex_md_start, md_done, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, md_timeout, stall_count
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds the ID instruction.
// Writes to r0 never create a dependency.
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic [4:0] ex_rt_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit     = (ex_rt_i == id_rs_i);
  assign rt_hit     = id_uses_rt_i & (ex_rt_i == id_rt_i);
  assign load_use_o = ex_mem_read_i & (ex_rt_i != REG_ZERO) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for PC and pipeline registers; Mealy outputs, zero added latency.
// Priority in RUN: dmem wait > taken branch > load-use > mul/div start; MD_WAIT guarded by a timeout.
module pipeline_hazard_controller
  import mips_pipe_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64
) (
  input logic                          clk,
  input logic                          rst,
  pipeline_hazard_controller_if.slave  hz
);

  localparam int              TMR_W    = $clog2(MD_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  md_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q;
  stage_ctrl_t      ctrl;
  logic             load_use;
  logic             md_release;

  load_use_detect u_load_use_detect (
    .id_rs_i       (hz.id_rs),
    .id_rt_i       (hz.id_rt),
    .id_uses_rt_i  (hz.id_uses_rt),
    .ex_rt_i       (hz.ex_rt),
    .ex_mem_read_i (hz.ex_mem_read),
    .load_use_o    (load_use)
  );

  assign md_release = hz.md_done | (timer_q == TMR_LAST);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    md_timeout_d = md_timeout_q;
    ctrl         = CTRL_RUN;

    case (state_q)
      RUN: begin
        if (!hz.dmem_ready) begin
          ctrl = CTRL_FREEZE;
        end else if (hz.ex_branch_taken) begin
          ctrl = CTRL_BRANCH;
        end else if (load_use) begin
          ctrl = CTRL_BUBBLE;
        end else if (hz.ex_md_start) begin
          ctrl    = CTRL_MDHOLD;
          state_d = MD_WAIT;
          timer_d = '0;
        end
      end
      MD_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // Release cycle uses default strobes so the mul/div instruction moves on.
        if (md_release) begin
          state_d = RUN;
          if (!hz.md_done) begin
            md_timeout_d = 1'b1;
          end
        end else begin
          ctrl = CTRL_MDHOLD;
        end
        if (!hz.dmem_ready) begin
          ctrl = CTRL_FREEZE;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (rst) begin
      ctrl = CTRL_FREEZE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      timer_q      <= '0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      md_timeout_q <= md_timeout_d;
      if (!ctrl.pc_en && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.pc_en       = ctrl.pc_en;
  assign hz.ifid_en     = ctrl.ifid_en;
  assign hz.idex_en     = ctrl.idex_en;
  assign hz.exmem_en    = ctrl.exmem_en;
  assign hz.memwb_en    = ctrl.memwb_en;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_flush  = ctrl.idex_flush;
  assign hz.exmem_flush = ctrl.exmem_flush;
  assign hz.md_timeout  = md_timeout_q;
  assign hz.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with CNT_W=4, MD_TIMEOUT=8.
// Control vector order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}.
module tb_pipeline_hazard_controller;

  localparam int CW = 4;
  localparam int MT = 8;

  localparam logic [7:0] E_DEF  = 8'b1111_1000;
  localparam logic [7:0] E_ZERO = 8'b0000_0000;
  localparam logic [7:0] E_BR   = 8'b1111_1110;
  localparam logic [7:0] E_LU   = 8'b0011_1010;
  localparam logic [7:0] E_MD   = 8'b0001_1001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pipeline_hazard_controller_if #(.CNT_W(CW)) hz ();

  pipeline_hazard_controller #(.CNT_W(CW), .MD_TIMEOUT(MT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  logic [7:0] ctl;
  assign ctl = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                hz.ifid_flush, hz.idex_flush, hz.exmem_flush};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_rs           = 5'd0;
    hz.id_rt           = 5'd0;
    hz.id_uses_rt      = 1'b0;
    hz.ex_rt           = 5'd0;
    hz.ex_mem_read     = 1'b0;
    hz.ex_branch_taken = 1'b0;
    hz.ex_md_start     = 1'b0;
    hz.md_done         = 1'b0;
    hz.dmem_ready      = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    #2;
    total++; if (ctl !== E_ZERO) begin bad++; $display("FAIL rst_ctl: got %b want %b", ctl, E_ZERO); end
    total++; if (hz.stall_count !== 4'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", hz.stall_count); end
    total++; if (hz.md_timeout !== 1'b0) begin bad++; $display("FAIL rst_to: got %b want 0", hz.md_timeout); end
    tick();
    rst = 1'b0;
    #2;
    total++; if (ctl !== E_DEF) begin bad++; $display("FAIL rst_release_ctl: got %b want %b", ctl, E_DEF); end
  endtask

  task automatic test_load_use();
    do_reset();
    hz.id_rs = 5'd5; hz.ex_rt = 5'd5; hz.ex_mem_read = 1'b1;
    #2;
    total++; if (ctl !== E_LU) begin bad++; $display("FAIL lu_rs: got %b want %b", ctl, E_LU); end
    tick();
    idle();
    #2;
    total++; if (ctl !== E_DEF) begin bad++; $display("FAIL lu_after: got %b want %b", ctl, E_DEF); end
    total++; if (hz.stall_count !== 4'd1) begin bad++; $display("FAIL lu_cnt: got %0d want 1", hz.stall_count); end
    hz.id_rs = 5'd0; hz.ex_rt = 5'd0; hz.ex_mem_read = 1'b1;
    #2;
    total++; if (ctl !== E_DEF) begin bad++; $display("FAIL lu_r0: got %b want %b", ctl, E_DEF); end
    hz.id_rs = 5'd3; hz.id_rt = 5'd7; hz.ex_rt = 5'd7; hz.id_uses_rt = 1'b1;
    #2;
    total++; if (ctl !== E_LU) begin bad++; $display("FAIL lu_rt: got %b want %b", ctl, E_LU); end
    hz.id_uses_rt = 1'b0;
    #2;
    total++; if (ctl !== E_DEF) begin bad++; $display("FAIL lu_rt_unused: got %b want %b", ctl, E_DEF); end
    hz.ex_mem_read = 1'b0; hz.id_rs = 5'd7;
    #2;
    total++; if (ctl !== E_DEF) begin bad++; $display("FAIL lu_noload: got %b want %b", ctl, E_DEF); end
    tick();
    total++; if (hz.stall_count !== 4'd1) begin bad++; $display("FAIL lu_cnt_hold: got %0d want 1", hz.stall_count); end
  endtask

  task automatic test_branch();
    do_reset();
    hz.id_rs = 5'd9; hz.ex_rt = 5'd9; hz.ex_mem_read = 1'b1;
    hz.ex_branch_taken = 1'b1; hz.ex_md_start = 1'b1;
    #2;
    total++; if (ctl !== E_BR) begin bad++; $display("FAIL br_ctl: got %b want %b", ctl, E_BR); end
    tick();
    idle();
    #2;
    total++; if (ctl !== E_DEF) begin bad++; $display("FAIL br_no_mdwait: got %b want %b", ctl, E_DEF); end
    total++; if (hz.stall_count !== 4'd0) begin bad++; $display("FAIL br_cnt: got %0d want 0", hz.stall_count); end
  endtask

  task automatic test_md_done();
    do_reset();
    hz.ex_md_start = 1'b1;
    #2;
    total++; if (ctl !== E_MD) begin bad++; $display("FAIL md_start: got %b want %b", ctl, E_MD); end
    tick();
    hz.ex_md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      total++; if (ctl !== E_MD) begin bad++; $display("FAIL md_wait%0d: got %b want %b", i, ctl, E_MD); end
      tick();
    end
    hz.md_done = 1'b1;
    #2;
    total++; if (ctl !== E_DEF) begin bad++; $display("FAIL md_done_ctl: got %b want %b", ctl, E_DEF); end
    tick();
    hz.md_done = 1'b0;
    #2;
    total++; if (ctl !== E_DEF) begin bad++; $display("FAIL md_back_run: got %b want %b", ctl, E_DEF); end
    total++; if (hz.stall_count !== 4'd6) begin bad++; $display("FAIL md_cnt: got %0d want 6", hz.stall_count); end
    total++; if (hz.md_timeout !== 1'b0) begin bad++; $display("FAIL md_no_to: got %b want 0", hz.md_timeout); end
  endtask

  task automatic test_md_timeout();
    do_reset();
    hz.ex_md_start = 1'b1;
    tick();
    hz.ex_md_start = 1'b0;
    for (int i = 0; i < MT - 1; i++) begin
      #2;
      total++; if (ctl !== E_MD) begin bad++; $display("FAIL to_wait%0d: got %b want %b", i, ctl, E_MD); end
      tick();
    end
    #2;
    total++; if (ctl !== E_DEF) begin bad++; $display("FAIL to_release: got %b want %b", ctl, E_DEF); end
    total++; if (hz.md_timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", hz.md_timeout); end
    tick();
    #2;
    total++; if (hz.md_timeout !== 1'b1) begin bad++; $display("FAIL to_set: got %b want 1", hz.md_timeout); end
    total++; if (hz.stall_count !== 4'd8) begin bad++; $display("FAIL to_cnt: got %0d want 8", hz.stall_count); end
    hz.id_rs = 5'd4; hz.ex_rt = 5'd4; hz.ex_mem_read = 1'b1;
    #1;
    total++; if (ctl !== E_LU) begin bad++; $display("FAIL to_run_lu: got %b want %b", ctl, E_LU); end
    tick();
    idle();
    tick();
    tick();
    total++; if (hz.md_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", hz.md_timeout); end
  endtask

  task automatic test_dmem_wait();
    do_reset();
    hz.ex_md_start = 1'b1;
    tick();
    hz.ex_md_start = 1'b0;
    #2;
    total++; if (ctl !== E_MD) begin bad++; $display("FAIL dm_md: got %b want %b", ctl, E_MD); end
    tick();
    hz.dmem_ready = 1'b0;
    #2;
    total++; if (ctl !== E_ZERO) begin bad++; $display("FAIL dm_w0: got %b want %b", ctl, E_ZERO); end
    tick();
    hz.md_done = 1'b1;
    #2;
    total++; if (ctl !== E_ZERO) begin bad++; $display("FAIL dm_w1_done: got %b want %b", ctl, E_ZERO); end
    tick();
    hz.md_done = 1'b0;
    #2;
    total++; if (ctl !== E_ZERO) begin bad++; $display("FAIL dm_w2: got %b want %b", ctl, E_ZERO); end
    tick();
    hz.dmem_ready = 1'b1;
    #2;
    total++; if (ctl !== E_DEF) begin bad++; $display("FAIL dm_run_after: got %b want %b", ctl, E_DEF); end
    total++; if (hz.stall_count !== 4'd5) begin bad++; $display("FAIL dm_cnt: got %0d want 5", hz.stall_count); end
    total++; if (hz.md_timeout !== 1'b0) begin bad++; $display("FAIL dm_no_to: got %b want 0", hz.md_timeout); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    hz.ex_md_start = 1'b1;
    tick();
    hz.ex_md_start = 1'b0;
    repeat (MT) tick();
    hz.ex_md_start = 1'b1;
    tick();
    hz.ex_md_start = 1'b0;
    #2;
    total++; if (hz.md_timeout !== 1'b1 || ctl !== E_MD) begin bad++; $display("FAIL rm_pre: got to=%b ctl=%b want to=1 ctl=%b", hz.md_timeout, ctl, E_MD); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (hz.stall_count !== 4'd0) begin bad++; $display("FAIL rm_cnt: got %0d want 0", hz.stall_count); end
    total++; if (hz.md_timeout !== 1'b0) begin bad++; $display("FAIL rm_to: got %b want 0", hz.md_timeout); end
    total++; if (ctl !== E_ZERO) begin bad++; $display("FAIL rm_ctl: got %b want %b", ctl, E_ZERO); end
    tick();
    rst = 1'b0;
    #2;
    total++; if (ctl !== E_DEF) begin bad++; $display("FAIL rm_run: got %b want %b", ctl, E_DEF); end
    tick();
    total++; if (hz.stall_count !== 4'd0) begin bad++; $display("FAIL rm_cnt_after: got %0d want 0", hz.stall_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    hz.dmem_ready = 1'b0;
    repeat (15) tick();
    total++; if (hz.stall_count !== 4'd15) begin bad++; $display("FAIL sat_15: got %0d want 15", hz.stall_count); end
    repeat (5) tick();
    total++; if (hz.stall_count !== 4'd15) begin bad++; $display("FAIL sat_20: got %0d want 15", hz.stall_count); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_md_done();
    test_md_timeout();
    test_dmem_wait();
    test_reset_mid_wait();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall and flush controller for the MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It generates per-stage enable and flush strobes from four sources, in priority order: data-memory wait, taken branch, load-use hazard, and the multi-cycle multiply/divide unit. It holds a small FSM for the multi-cycle wait with a timeout guard, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- CNT_W, 16, width of stall_count
- MD_TIMEOUT, 64, max cycles in MD_WAIT before forced release (≥2)

- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  5  source registers of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_rt  in  5  destination of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- ex_md_start  in  1  EX holds a mult/div; unit starts this cycle
- md_done  in  1  mult/div result valid (1-cycle pulse)
- dmem_ready  in  1  data memory can complete this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage register load enables
- ifid_flush, idex_flush, exmem_flush  out  1  load NOP/bubble instead of data
- md_timeout  out  1  sticky error flag
- stall_count  out  CNT_W  saturating count of cycles with pc_en=0

## Operation
- FSM states: RUN, MD_WAIT. Reset → RUN.
- Outputs are Mealy (state + current inputs). Default: all en=1, all flush=0.
- load_use = ex_mem_read & (ex_rt≠0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- RUN, first match wins:
  - dmem_ready=0: all en=0, no flush; state holds.
  - ex_branch_taken: ifid_flush=1, idex_flush=1; pc loads target; ex_md_start ignored.
  - load_use: pc_en=0, ifid_en=0, idex_flush=1 (one bubble).
  - ex_md_start: pc_en=ifid_en=idex_en=0, exmem_flush=1; next state MD_WAIT; timer cleared.
  - md_done is ignored in RUN.
- MD_WAIT:
  - Timer increments every cycle.
  - md_done=1 or timer==MD_TIMEOUT-1: next state RUN. The cycle's outputs are the defaults (the mul/div instruction advances). On timeout with md_done=0, md_timeout is set.
  - Otherwise: pc_en=ifid_en=idex_en=0, exmem_flush=1, memwb_en=1.
  - dmem_ready=0 overrides to all en=0 and no flush. The transition and timer still proceed.
  - ex_branch_taken and load_use are ignored.
- stall_count increments when pc_en=0 and rst=0. It saturates at all-ones.
- md_timeout is cleared only by rst.

## Timing
- Hazard responses are combinational, in the same cycle as the triggering inputs. There is no added latency.
- Load-use costs exactly 1 bubble. A taken branch costs 2 flushed slots.
- A mult/div with done arriving N cycles after start stalls the front end N+1 cycles.
- Reset, asynchronous:
  - state=RUN, timer=0, stall_count=0, md_timeout=0.
  - While rst=1, force all en=0 and all flush=0.
- Reset mid-MD_WAIT: returns to RUN immediately. The first cycle after release behaves as RUN.

## Structure
- Package mips_pipe_pkg holds:
  - the FSM state encoding (RUN=1'b0, MD_WAIT=1'b1);
  - the NOP constant 32'h0000_0000 used by the flushed registers;
  - the register-zero constant 5'd0.
- Sub-module load_use_detect: purely combinational comparator producing load_use.
- The FSM, timer and counter stay in the top module.

## Test plan
- id_rs=5, ex_rt=5, ex_mem_read=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; ex_rt=0 with the same setup → no stall.
- ex_branch_taken=1 together with load_use=1 → ifid_flush=idex_flush=1, pc_en=1, stall_count unchanged.
- ex_md_start pulse, md_done 5 cycles later → front-end enables low for 5 cycles plus the start cycle, all enables high on the done cycle, stall_count=6.
- ex_md_start, md_done never asserted, MD_TIMEOUT=8 → return to RUN after 8 cycles in MD_WAIT, md_timeout=1 and stays set.
- dmem_ready=0 held 3 cycles during MD_WAIT, with md_done in the middle → all en=0 during the wait, state=RUN afterward.
- rst asserted mid-MD_WAIT → state RUN, stall_count=0, md_timeout=0 asynchronously; CNT_W=4 with 20 stalls → stall_count=15.
